// File: rtl/clkdiv_ctrl_if.sv
// Config port of the clock divider controller.
// Valid/ready offer of a new half-period plus the discard pulse.
interface clkdiv_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_half;
  logic             cfg_ready;
  logic             cfg_err;

  modport master (
    output cfg_valid,
    output cfg_half,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_half,
    output cfg_ready,
    output cfg_err
  );
endinterface

// File: rtl/clkdiv_ctrl.sv
// Run/stop and ratio controller for the square-wave clock divider.
// Ratio changes and stops land only on half-period boundaries.
module clkdiv_ctrl #(
  parameter int CNT_W        = 8,
  parameter int DEFAULT_HALF = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  clkdiv_ctrl_if.slave cfg,
  output logic        divided_clk,
  output logic        tick_rise,
  output logic        tick_fall,
  output logic        busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STOP = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] act_half;
  logic [CNT_W-1:0] pend_half;
  logic             pend;
  logic             err_q;
  logic             bnd;
  logic             xfer;
  logic             zero;
  logic             counting;
  logic             to_idle;

  assign bnd  = (cnt == act_half - CNT_W'(1));
  assign xfer = cfg.cfg_valid && !pend;
  assign zero = (cfg.cfg_half == '0);

  assign cfg.cfg_ready = !pend;
  assign cfg.cfg_err   = err_q;
  assign busy          = (state != S_IDLE);
  assign to_idle       = (state_nx == S_IDLE);

  always_comb begin
    state_nx = state;
    counting = 1'b0;
    unique case (1'b1)
      (state == S_IDLE): begin
        if (enable)
          state_nx = S_RUN;
      end
      (state == S_RUN): begin
        // a low phase may be cut short; a high phase must finish
        if (!enable && !divided_clk) begin
          state_nx = S_IDLE;
        end else begin
          counting = 1'b1;
          if (!enable)
            state_nx = bnd ? S_IDLE : S_STOP;
        end
      end
      (state == S_STOP): begin
        counting = 1'b1;
        if (enable)
          state_nx = S_RUN;
        else if (bnd)
          state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      act_half    <= CNT_W'(DEFAULT_HALF);
      pend_half   <= '0;
      pend        <= 1'b0;
      divided_clk <= 1'b0;
      tick_rise   <= 1'b0;
      tick_fall   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state     <= state_nx;
      tick_rise <= 1'b0;
      tick_fall <= 1'b0;
      err_q     <= xfer && zero;

      if (counting) begin
        if (bnd) begin
          cnt         <= '0;
          divided_clk <= !divided_clk;
          tick_rise   <= !divided_clk;
          tick_fall   <= divided_clk;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end

      // pend set in the cycle we fell into IDLE is drained here too
      if (pend && ((counting && bnd) || to_idle ||
                   state == S_IDLE)) begin
        act_half <= pend_half;
        pend     <= 1'b0;
      end

      if (xfer && !zero) begin
        if (state == S_IDLE) begin
          act_half <= cfg.cfg_half;
        end else begin
          pend_half <= cfg.cfg_half;
          pend      <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/clkdiv_ctrl.md
Name: clkdiv_ctrl

Overview:
Run/stop and ratio controller for the team's square-wave clock divider. It owns the half-period counter and the divided clock output, and accepts new divide ratios over a valid/ready config port. Ratio changes and stops are applied only at half-period boundaries, so divided_clk never glitches or produces a runt pulse. It sits between the system config logic and any logic clocked or enabled by the divided clock.

Parameters:
CNT_W, 8, width of the half-period counter and of cfg_half; legal half range is 1..2^CNT_W-1.
DEFAULT_HALF, 10, half-period in clk cycles loaded at reset; the reset output period is 20 cycles.

Ports:
clk  in  1  system clock; all logic is on its rising edge
reset  in  1  asynchronous, active-high reset
enable  in  1  level; 1 = run the divider, 0 = stop at the next safe point
cfg_valid  in  1  new half-period offered
cfg_half  in  CNT_W  offered half-period in clk cycles
cfg_ready  out  1  controller can accept a config
cfg_err  out  1  one-cycle pulse: accepted config was 0 and was discarded
divided_clk  out  1  divided clock, 50% duty, period 2*act_half
tick_rise  out  1  one-cycle pulse in the cycle divided_clk first reads 1
tick_fall  out  1  one-cycle pulse in the cycle divided_clk first reads 0
busy  out  1  1 whenever state != IDLE

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, port name reset. All outputs are registered except cfg_ready and busy, which are decoded from registers.
- Reset values: state=IDLE, counter=0, act_half=DEFAULT_HALF, pend=0, divided_clk=0, tick_rise=0, tick_fall=0, cfg_err=0.
- Reset asserted mid-operation clears everything at once; the pending config is discarded.
- Config handshake:
  - cfg_ready = !pend. A transfer occurs when cfg_valid && cfg_ready.
  - cfg_half==0: cfg_err=1 on the next cycle; nothing else changes.
  - State IDLE: act_half <= cfg_half at the next edge.
  - Any other state: pend_half <= cfg_half, pend <= 1. cfg_ready stays low until the value is applied.
- States:
  - IDLE: counter held at 0, divided_clk=0.
    - enable=1 -> RUN. The first RUN cycle has counter=0.
  - RUN: counter increments each cycle.
    - Boundary is counter==act_half-1. At the boundary: counter<=0, divided_clk toggles, and the matching tick pulses together with the new level.
    - If pend at the boundary: act_half<=pend_half, pend<=0. The new half applies from the next half-period.
    - enable=0 with divided_clk=0: -> IDLE next edge, counter<=0. Only the low phase is truncated, which is glitch-free.
    - enable=0 with divided_clk=1: -> STOP.
  - STOP: keeps counting the high phase with normal boundary and pending rules.
    - At the falling boundary -> IDLE. tick_fall pulses.
    - enable=1 before that boundary -> RUN with the count undisturbed.
- Entering IDLE with pend=1 applies pend_half that cycle and clears pend.
- Simultaneous events: a config accepted in the same cycle as a boundary is not applied at that boundary (pend was empty when sampled); it applies at the following boundary.
- act_half=1 gives clk/2: divided_clk toggles every cycle, and tick_rise/tick_fall alternate every cycle.
- Counter is CNT_W bits and never exceeds act_half-1; no wrap beyond that.

Test Plan:
- Reset defaults, enable=1 from edge 0 -> RUN after edge 0; divided_clk rises at edge 10, falls at edge 20, period 20; tick_rise one cycle at each rise; busy=1.
- In IDLE, write cfg_half=3 then enable -> period 6, high and low exactly 3 cycles each; cfg_ready stays 1 throughout.
- In RUN with half=10, write cfg_half=4 mid-high-phase -> cfg_ready=0; current high phase stays 10 cycles; subsequent half-periods are 4; cfg_ready returns to 1 at that boundary.
- Drop enable 2 cycles into a high phase (half=10) -> output stays high 8 more cycles, falls with tick_fall, then IDLE; busy=0; no pulse shorter than 10 cycles.
- Write cfg_half=0 -> cfg_err one cycle, act_half unchanged, period still 20; then assert reset mid-high-phase with pend set -> divided_clk=0, pend cleared, act_half=10 immediately.
- cfg_half=1 -> divided_clk toggles every clk cycle; a config offered on a boundary cycle takes effect one half-period later.
